freq_monitor: RTL and testbench

Multi-channel frequency monitor: measures up to NUM_CH asynchronous clocks against the local reference clock and flags each channel as in or out of a programmable count range. Each monitored clock domain supplies a toggle signal (a divide-by-2 flop in that domain). Toggles are synchronised here, and transitions are counted over a programmable window of reference cycles. Supports one-shot and continuous modes, per-channel low/high thresholds, abort and saturation reporting. Sits in the clock-health block and feeds the fault aggregator.

---
 rtl/freq_monitor_pkg.sv | 20 ++
 rtl/freq_monitor_ch.sv | 103 ++++++++++
 rtl/freq_monitor.sv | 135 +++++++++++++
 tb/tb_freq_monitor.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_monitor_pkg.sv
// -----------------------------------------------------------------------------
// freq_monitor_pkg
//   Shared types and limits for the multi-channel frequency monitor.
//   - fm_state_t        : measurement sequencer states
//   - FM_SYNC_STAGE_MIN : smallest usable synchroniser depth
//   - FM_NUM_CH_MAX     : largest supported channel count
// -----------------------------------------------------------------------------
package freq_monitor_pkg;

  typedef enum logic [1:0] {
    FM_IDLE  = 2'd0,
    FM_ARM   = 2'd1,
    FM_COUNT = 2'd2,
    FM_EVAL  = 2'd3
  } fm_state_t;

  localparam int unsigned FM_SYNC_STAGE_MIN = 2;
  localparam int unsigned FM_NUM_CH_MAX     = 16;

endpackage

// File: rtl/freq_monitor_ch.sv
// -----------------------------------------------------------------------------
// freq_monitor_ch
//   One monitored channel: synchronises the asynchronous toggle input, turns
//   each toggle transition into a one-cycle event, counts events while
//   count_en is high (saturating at all-ones), and on eval compares the count
//   with the thresholds captured at the last clear.
//
// Ports
//   clk, reset_n : reference clock, synchronous active-low reset
//   toggle       : asynchronous divide-by-2 signal from the monitored domain
//   clear        : zero the counter / sat bit and snapshot thr_lo, thr_hi
//   count_en     : count events this cycle
//   eval         : register count and comparison results
//   thr_lo/hi    : live thresholds (only sampled on clear)
//   count        : last evaluated event count
//   ge_lo, le_hi : count >= thr_lo, count <= thr_hi (unsigned)
//   in_range     : ge_lo && le_hi
//   sat          : counter reached all-ones during the evaluated window
// -----------------------------------------------------------------------------
module freq_monitor_ch #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SYNC_STAGE = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  toggle,
  input  logic                  clear,
  input  logic                  count_en,
  input  logic                  eval,
  input  logic [DATA_WIDTH-1:0] thr_lo,
  input  logic [DATA_WIDTH-1:0] thr_hi,
  output logic [DATA_WIDTH-1:0] count,
  output logic                  ge_lo,
  output logic                  le_hi,
  output logic                  in_range,
  output logic                  sat
);

  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

  logic [SYNC_STAGE-1:0] sync_q;
  logic                  prev_q;
  logic                  evt;

  logic [DATA_WIDTH-1:0] cnt_q;
  logic [DATA_WIDTH-1:0] cnt_inc;
  logic                  sat_q;
  logic [DATA_WIDTH-1:0] thr_lo_q;
  logic [DATA_WIDTH-1:0] thr_hi_q;
  logic                  ge_now;
  logic                  le_now;

  // Synchroniser and previous-value register run unconditionally and carry
  // no reset; any spurious event after reset falls into IDLE and is ignored.
  always_ff @(posedge clk) begin
    sync_q <= {sync_q[SYNC_STAGE-2:0], toggle};
    prev_q <= sync_q[SYNC_STAGE-1];
  end

  // Each transition of the synchronised toggle marks one monitored rising edge.
  assign evt     = sync_q[SYNC_STAGE-1] ^ prev_q;
  assign cnt_inc = cnt_q + ONE;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      sat_q    <= 1'b0;
      thr_lo_q <= '0;
      thr_hi_q <= '0;
    end else if (clear) begin
      cnt_q    <= '0;
      sat_q    <= 1'b0;
      thr_lo_q <= thr_lo;
      thr_hi_q <= thr_hi;
    end else if (count_en && evt && (cnt_q != '1)) begin
      cnt_q <= cnt_inc;
      // Reaching all-ones means the true count may exceed what is reported.
      if (&cnt_inc) begin
        sat_q <= 1'b1;
      end
    end
  end

  assign ge_now = (cnt_q >= thr_lo_q);
  assign le_now = (cnt_q <= thr_hi_q);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count    <= '0;
      ge_lo    <= 1'b0;
      le_hi    <= 1'b0;
      in_range <= 1'b0;
      sat      <= 1'b0;
    end else if (eval) begin
      count    <= cnt_q;
      ge_lo    <= ge_now;
      le_hi    <= le_now;
      in_range <= ge_now & le_now;
      sat      <= sat_q;
    end
  end

endmodule

// File: rtl/freq_monitor.sv
// -----------------------------------------------------------------------------
// freq_monitor
//   Multi-channel frequency monitor. Counts toggle transitions of NUM_CH
//   asynchronous clocks over a programmable window of reference cycles and
//   flags each channel as inside or outside its [thr_lo, thr_hi] range.
//   Sequencer: IDLE -> ARM (1 cycle) -> COUNT (max(window,1) cycles)
//   -> EVAL (1 cycle) -> ARM (continuous) or IDLE.
//
// Ports
//   clk, reset_n : reference clock, synchronous active-low reset
//   ch_toggle    : per-channel asynchronous toggle inputs
//   start        : begin a measurement (IDLE only)
//   stop         : abort (any non-IDLE state); no done, results untouched
//   continuous   : re-arm after EVAL (sampled in EVAL)
//   window       : window length in clk cycles, 0 behaves as 1
//   thr_lo/hi    : per-channel inclusive bounds, channel n at [n*DW +: DW]
//   busy         : measurement in progress (ARM/COUNT/EVAL)
//   done         : one-cycle pulse, new results valid
//   count        : per-channel last completed count, channel n at [n*DW +: DW]
//   ge_lo, le_hi, in_range, sat : per-channel result flags
// -----------------------------------------------------------------------------
module freq_monitor
  import freq_monitor_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SYNC_STAGE = 3
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_CH-1:0]            ch_toggle,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         continuous,
  input  logic [DATA_WIDTH-1:0]        window,
  input  logic [NUM_CH*DATA_WIDTH-1:0] thr_lo,
  input  logic [NUM_CH*DATA_WIDTH-1:0] thr_hi,
  output logic                         busy,
  output logic                         done,
  output logic [NUM_CH*DATA_WIDTH-1:0] count,
  output logic [NUM_CH-1:0]            ge_lo,
  output logic [NUM_CH-1:0]            le_hi,
  output logic [NUM_CH-1:0]            in_range,
  output logic [NUM_CH-1:0]            sat
);

  localparam int unsigned SYNC_N =
    (SYNC_STAGE < FM_SYNC_STAGE_MIN) ? FM_SYNC_STAGE_MIN : SYNC_STAGE;
  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

  fm_state_t             state_q;
  fm_state_t             state_d;
  logic [DATA_WIDTH-1:0] rem_q;
  logic                  last_cycle;
  logic                  clear;
  logic                  count_en;
  logic                  eval_en;

  // Remaining COUNT cycles, loaded in ARM; COUNT ends when it reads one.
  assign last_cycle = (rem_q == ONE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= FM_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FM_IDLE:  if (start && !stop) state_d = FM_ARM;
      FM_ARM:   state_d = stop ? FM_IDLE : FM_COUNT;
      FM_COUNT: begin
        if (stop)            state_d = FM_IDLE;
        else if (last_cycle) state_d = FM_EVAL;
      end
      FM_EVAL: begin
        if (stop)            state_d = FM_IDLE;
        else if (continuous) state_d = FM_ARM;
        else                 state_d = FM_IDLE;
      end
      default:  state_d = FM_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != FM_IDLE);
    clear    = (state_q == FM_ARM);
    count_en = (state_q == FM_COUNT);
    // An abort in EVAL must leave the previous results and suppress done.
    eval_en  = (state_q == FM_EVAL) && !stop;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rem_q <= '0;
    end else if (state_q == FM_ARM) begin
      rem_q <= (window == '0) ? ONE : window;
    end else if (state_q == FM_COUNT) begin
      rem_q <= rem_q - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      done <= 1'b0;
    end else begin
      done <= eval_en;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    freq_monitor_ch #(
      .DATA_WIDTH (DATA_WIDTH),
      .SYNC_STAGE (SYNC_N)
    ) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .toggle   (ch_toggle[g]),
      .clear    (clear),
      .count_en (count_en),
      .eval     (eval_en),
      .thr_lo   (thr_lo[g*DATA_WIDTH +: DATA_WIDTH]),
      .thr_hi   (thr_hi[g*DATA_WIDTH +: DATA_WIDTH]),
      .count    (count[g*DATA_WIDTH +: DATA_WIDTH]),
      .ge_lo    (ge_lo[g]),
      .le_hi    (le_hi[g]),
      .in_range (in_range[g]),
      .sat      (sat[g])
    );
  end

endmodule

// File: tb/tb_freq_monitor.sv
module tb_freq_monitor;

  localparam int NCH  = 4;
  localparam int DW   = 32;
  localparam int SS   = 3;
  localparam int SDW  = 4;
  localparam int MAXC = 8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic                reset_n;
  logic [NCH-1:0]      ch_toggle = '0;
  logic                start, stop, continuous;
  logic [DW-1:0]       window;
  logic [NCH*DW-1:0]   thr_lo, thr_hi;
  logic                busy, done;
  logic [NCH*DW-1:0]   count;
  logic [NCH-1:0]      ge_lo, le_hi, in_range, sat;

  // narrow single-channel instance for saturation
  logic [0:0]          s_toggle = '0;
  logic                s_start, s_stop, s_cont;
  logic [SDW-1:0]      s_window, s_thr_lo, s_thr_hi;
  logic                s_busy, s_done;
  logic [SDW-1:0]      s_count;
  logic [0:0]          s_ge, s_le, s_in, s_sat;

  freq_monitor #(.NUM_CH(NCH), .DATA_WIDTH(DW), .SYNC_STAGE(SS)) dut (
    .clk(clk), .reset_n(reset_n), .ch_toggle(ch_toggle), .start(start),
    .stop(stop), .continuous(continuous), .window(window),
    .thr_lo(thr_lo), .thr_hi(thr_hi), .busy(busy), .done(done),
    .count(count), .ge_lo(ge_lo), .le_hi(le_hi), .in_range(in_range),
    .sat(sat)
  );

  freq_monitor #(.NUM_CH(1), .DATA_WIDTH(SDW), .SYNC_STAGE(SS)) dut_s (
    .clk(clk), .reset_n(reset_n), .ch_toggle(s_toggle), .start(s_start),
    .stop(s_stop), .continuous(s_cont), .window(s_window),
    .thr_lo(s_thr_lo), .thr_hi(s_thr_hi), .busy(s_busy), .done(s_done),
    .count(s_count), .ge_lo(s_ge), .le_hi(s_le), .in_range(s_in),
    .sat(s_sat)
  );

  // cycle index: during cycle c (after posedge c) cyc == c
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // toggle generators; every transition is logged per cycle for the model
  int period [NCH];   // 0 static, >0 toggle every period cycles, <0 random
  bit chg [NCH][MAXC];
  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      bit f;
      f = 1'b0;
      if (period[c] > 0)      f = ((cyc % period[c]) == 0);
      else if (period[c] < 0) f = ($urandom_range(0, 2) == 0);
      if (f) ch_toggle[c] = ~ch_toggle[c];
      if (cyc < MAXC) chg[c][cyc] = f;
    end
    s_toggle = ~s_toggle;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model: a transition logged in cycle k is seen as an event in
  // cycle k+SS; done in cycle d closes a window whose W counting cycles are
  // d-W-1 .. d-2.
  function automatic longint model_raw(input int c, input int d, input int w);
    int wl;
    longint n;
    wl = (w == 0) ? 1 : w;
    n = 0;
    for (int k = d - wl - 1; k <= d - 2; k++) begin
      if (k - SS >= 0 && k - SS < MAXC && chg[c][k - SS]) n++;
    end
    return n;
  endfunction

  logic [NCH-1:0][DW-1:0] exp_lo, exp_hi, last_cnt;
  logic [NCH-1:0]         last_ge, last_le, last_in, last_sat;

  task automatic expect_from_model(input int d, input int w);
    longint n;
    longint maxv;
    maxv = (64'sd1 <<< DW) - 1;
    for (int c = 0; c < NCH; c++) begin
      n = model_raw(c, d, w);
      last_sat[c] = (n >= maxv);
      if (n > maxv) n = maxv;
      last_cnt[c] = DW'(n);
      last_ge[c]  = (last_cnt[c] >= exp_lo[c]);
      last_le[c]  = (last_cnt[c] <= exp_hi[c]);
      last_in[c]  = last_ge[c] && last_le[c];
    end
  endtask

  task automatic check_outputs(input string tag);
    for (int c = 0; c < NCH; c++)
      chk($sformatf("%s_count%0d", tag, c), 64'(count[c*DW +: DW]), 64'(last_cnt[c]));
    chk({tag, "_ge_lo"},    64'(ge_lo),    64'(last_ge));
    chk({tag, "_le_hi"},    64'(le_hi),    64'(last_le));
    chk({tag, "_in_range"}, 64'(in_range), 64'(last_in));
    chk({tag, "_sat"},      64'(sat),      64'(last_sat));
  endtask

  task automatic set_thr(input logic [NCH-1:0][DW-1:0] lo, input logic [NCH-1:0][DW-1:0] hi);
    exp_lo = lo;
    exp_hi = hi;
    thr_lo = lo;
    thr_hi = hi;
  endtask

  task automatic wait_done(input int bound, output int d);
    d = -1;
    for (int i = 0; i < bound; i++) begin
      if (done) begin
        d = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  // called at a negedge; start is high during cycle s
  task automatic do_run(input int w, input bit perturb, output int s, output int d);
    int wl;
    wl = (w == 0) ? 1 : w;
    window = DW'(w);
    start  = 1'b1;
    s      = cyc;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    if (perturb) begin
      window = $urandom;
      thr_lo = {$urandom, $urandom, $urandom, $urandom};
      thr_hi = {$urandom, $urandom, $urandom, $urandom};
    end
    wait_done(wl + 20, d);
    chk("done_cycle", 64'(d), 64'(s + wl + 3));
  endtask

  typedef struct {
    int                     window;
    logic [NCH-1:0][DW-1:0] lo;
    logic [NCH-1:0][DW-1:0] hi;
    logic [NCH-1:0][DW-1:0] cnt;
    logic [NCH-1:0]         ge;
    logic [NCH-1:0]         le;
    logic [NCH-1:0]         inr;
  } vec_t;

  vec_t tv [4];
  int s, d, d3, nbad, ss, sd, w;
  int dd [3];
  logic [NCH-1:0][DW-1:0] rlo, rhi;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected bench completion (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; continuous = 1'b0;
    window = '0; thr_lo = '0; thr_hi = '0;
    s_start = 1'b0; s_stop = 1'b0; s_cont = 1'b0;
    s_window = '0; s_thr_lo = '0; s_thr_hi = '0;
    exp_lo = '0; exp_hi = '0; last_cnt = '0;
    last_ge = '0; last_le = '0; last_in = '0; last_sat = '0;
    period = '{2, 0, 1, 4};

    // ---- reset with random inputs ----
    repeat (6) begin
      @(negedge clk);
      start = 1'($urandom); stop = 1'($urandom); continuous = 1'($urandom);
      window = $urandom;
      thr_lo = {$urandom, $urandom, $urandom, $urandom};
      thr_hi = {$urandom, $urandom, $urandom, $urandom};
      s_start = 1'($urandom); s_window = 4'($urandom);
    end
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_count", 64'(count != '0), 64'(0));
    chk("rst_flags", 64'({ge_lo, le_hi, in_range, sat}), 64'(0));
    chk("rst_small", 64'({s_busy, s_done, s_count, s_ge, s_le, s_in, s_sat}), 64'(0));
    start = 1'b0; stop = 1'b0; continuous = 1'b0; s_start = 1'b0;
    reset_n = 1'b1;
    nbad = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy || s_done || s_busy) nbad++;
    end
    chk("idle_after_reset", 64'(nbad), 64'(0));

    // ---- table-driven: ch0 period 2, ch1 static, ch2 every cycle, ch3 period 4 ----
    tv[0].window = 100;
    tv[0].lo  = {32'd25, 32'd45, 32'd45, 32'd45};
    tv[0].hi  = {32'd25, 32'd55, 32'd55, 32'd55};
    tv[0].cnt = {32'd25, 32'd100, 32'd0, 32'd50};
    tv[0].ge = 4'b1101; tv[0].le = 4'b1011; tv[0].inr = 4'b1001;
    tv[1].window = 8;
    tv[1].lo  = {32'd3, 32'd8, 32'd0, 32'd10};
    tv[1].hi  = {32'd1, 32'hFFFF_FFFF, 32'd0, 32'd5};
    tv[1].cnt = {32'd2, 32'd8, 32'd0, 32'd4};
    tv[1].ge = 4'b0110; tv[1].le = 4'b0111; tv[1].inr = 4'b0110;
    tv[2].window = 40;
    tv[2].lo  = {32'd11, 32'hFFFF_FFFF, 32'd1, 32'd20};
    tv[2].hi  = {32'd9, 32'hFFFF_FFFF, 32'd0, 32'd20};
    tv[2].cnt = {32'd10, 32'd40, 32'd0, 32'd20};
    tv[2].ge = 4'b0001; tv[2].le = 4'b0111; tv[2].inr = 4'b0001;
    tv[3].window = 12;
    tv[3].lo  = {32'd3, 32'd0, 32'd0, 32'd7};
    tv[3].hi  = {32'd3, 32'd11, 32'd0, 32'd6};
    tv[3].cnt = {32'd3, 32'd12, 32'd0, 32'd6};
    tv[3].ge = 4'b1110; tv[3].le = 4'b1011; tv[3].inr = 4'b1010;

    for (int i = 0; i < 4; i++) begin
      set_thr(tv[i].lo, tv[i].hi);
      do_run(tv[i].window, 1'b0, s, d);
      last_cnt = tv[i].cnt; last_ge = tv[i].ge; last_le = tv[i].le;
      last_in = tv[i].inr; last_sat = '0;
      check_outputs($sformatf("vec%0d", i));
      @(negedge clk);
      chk("done_one_cycle", 64'(done), 64'(0));
    end

    // ---- window = 0 behaves as 1 ----
    set_thr({4{32'd1}}, {4{32'd1}});
    do_run(0, 1'b0, s, d);
    expect_from_model(d, 0);
    check_outputs("win0");
    @(negedge clk);

    // ---- randomized runs against the model ----
    for (int it = 0; it < 25; it++) begin
      for (int c = 0; c < NCH; c++) begin
        case ($urandom_range(0, 6))
          0: period[c] = -1;
          1: period[c] = 0;
          2: period[c] = 1;
          3: period[c] = 2;
          4: period[c] = 3;
          5: period[c] = 5;
          default: period[c] = -1;
        endcase
        case ($urandom_range(0, 7))
          0: rlo[c] = '0;
          1: rlo[c] = '1;
          default: rlo[c] = DW'($urandom_range(0, 35));
        endcase
        case ($urandom_range(0, 7))
          0: rhi[c] = '0;
          1: rhi[c] = '1;
          default: rhi[c] = DW'($urandom_range(0, 35));
        endcase
      end
      set_thr(rlo, rhi);
      w = $urandom_range(0, 60);
      do_run(w, 1'(it % 2), s, d);
      expect_from_model(d, w);
      check_outputs($sformatf("rnd%0d", it));
      @(negedge clk);
    end

    // ---- continuous mode, then leave it mid-COUNT ----
    period = '{-1, 2, 3, 0};
    set_thr({32'd2, 32'd1, 32'd4, 32'd3}, {32'd6, 32'd5, 32'd6, 32'd0});
    continuous = 1'b1;
    window = DW'(10);
    start = 1'b1; s = cyc;
    @(negedge clk);
    start = 1'b0;
    for (int p = 0; p < 3; p++) begin
      wait_done(40, dd[p]);
      expect_from_model(dd[p], 10);
      check_outputs($sformatf("cont%0d", p));
      @(negedge clk);
    end
    chk("cont_first_done", 64'(dd[0]), 64'(s + 13));
    chk("cont_period1", 64'(dd[1] - dd[0]), 64'(12));
    chk("cont_period2", 64'(dd[2] - dd[1]), 64'(12));
    while (cyc < dd[2] + 5) @(negedge clk);
    continuous = 1'b0;
    wait_done(40, d3);
    chk("cont_last_done", 64'(d3), 64'(dd[2] + 12));
    expect_from_model(d3, 10);
    check_outputs("cont_last");
    @(negedge clk);
    chk("cont_busy_end", 64'(busy), 64'(0));
    nbad = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) nbad++;
    end
    chk("cont_no_more_done", 64'(nbad), 64'(0));

    // ---- abort at cycle 50 of a 100-cycle window ----
    window = DW'(100);
    thr_lo = '1; thr_hi = '0;
    start = 1'b1; s = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc < s + 50) @(negedge clk);
    chk("abort_busy_before", 64'(busy), 64'(1));
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("abort_busy_after", 64'(busy), 64'(0));
    nbad = 0;
    repeat (110) begin
      @(negedge clk);
      if (done) nbad++;
    end
    chk("abort_no_done", 64'(nbad), 64'(0));
    check_outputs("abort_hold");

    // ---- measurement after abort ----
    set_thr({32'd0, 32'd5, 32'd10, 32'd15}, {32'd30, 32'd20, 32'd12, 32'd15});
    do_run(30, 1'b0, s, d);
    expect_from_model(d, 30);
    check_outputs("after_abort");
    @(negedge clk);

    // ---- start during COUNT is ignored ----
    window = DW'(20);
    start = 1'b1; s = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc < s + 10) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(40, d);
    chk("restart_ignored_done", 64'(d), 64'(s + 23));
    expect_from_model(d, 20);
    check_outputs("restart_ignored");
    nbad = 0;
    repeat (30) begin
      @(negedge clk);
      if (done || busy) nbad++;
    end
    chk("restart_ignored_idle", 64'(nbad), 64'(0));

    // ---- start and stop together in IDLE ----
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    nbad = 0;
    repeat (10) begin
      if (done || busy) nbad++;
      @(negedge clk);
    end
    chk("start_stop_idle", 64'(nbad), 64'(0));

    // ---- saturation on the 4-bit instance (event every cycle) ----
    s_window = 4'd15; s_thr_lo = 4'd3; s_thr_hi = 4'd14;
    s_start = 1'b1; ss = cyc;
    @(negedge clk);
    s_start = 1'b0;
    sd = -1;
    for (int i = 0; i < 40; i++) begin
      if (s_done) begin sd = cyc; break; end
      @(negedge clk);
    end
    chk("sat_done_cycle", 64'(sd), 64'(ss + 18));
    chk("sat_count", 64'(s_count), 64'(15));
    chk("sat_flag", 64'(s_sat), 64'(1));
    chk("sat_le_hi", 64'(s_le), 64'(0));
    chk("sat_ge_lo", 64'(s_ge), 64'(1));
    chk("sat_in_range", 64'(s_in), 64'(0));
    @(negedge clk);
    s_window = 4'd10;
    s_start = 1'b1; ss = cyc;
    @(negedge clk);
    s_start = 1'b0;
    sd = -1;
    for (int i = 0; i < 40; i++) begin
      if (s_done) begin sd = cyc; break; end
      @(negedge clk);
    end
    chk("nosat_done_cycle", 64'(sd), 64'(ss + 13));
    chk("nosat_count", 64'(s_count), 64'(10));
    chk("nosat_flag", 64'(s_sat), 64'(0));
    chk("nosat_in_range", 64'({s_ge, s_le, s_in}), 64'(3'b111));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
